serial_subtractor_ctrl: RTL and testbench

- Bit-serial multi-bit subtractor controller. It sequences one 1-bit full-subtractor cell (d = a^b^br, borrow = ~a&b | ~(a^b)&br) over a WIDTH-bit operand pair, LSB first, one bit per clock.
- It sits between a requester issuing start/operands and the shared 1-bit subtract datapath. It returns the difference, the borrow out and the signed overflow with a start/busy/done handshake.
- It is the sequential companion to the team's half/full subtractor cells: the same arithmetic, stretched over time to save area.

---
 rtl/serial_subtractor_ctrl.sv | 128 ++++++++++++
 tb/tb_serial_subtractor_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial WIDTH-bit subtractor controller.
// Runs one full-subtractor cell LSB first, one bit per clock.
module serial_subtractor_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t state;
    state_t state_nx;

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] res_nx;
    logic [CW-1:0]    cnt;
    logic             br;
    logic             a_msb;
    logic             b_msb;
    logic             cell_d;
    logic             cell_b;
    logic             last;

    assign cell_d = a_sr[0] ^ b_sr[0] ^ br;
    assign cell_b = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);
    assign res_nx = {cell_d, res[WIDTH-1:1]};
    assign last   = (cnt == LAST);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state and decoded handshake outputs.
    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (last) begin
                    state_nx = S_DONE;
                end
            end
            S_DONE: begin
                busy     = 1'b1;
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // Operand shifters, borrow chain and bit counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr  <= '0;
            b_sr  <= '0;
            res   <= '0;
            br    <= 1'b0;
            cnt   <= '0;
            a_msb <= 1'b0;
            b_msb <= 1'b0;
        end else if (state == S_IDLE && start) begin
            a_sr  <= a;
            b_sr  <= b;
            res   <= '0;
            br    <= bin;
            cnt   <= '0;
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
        end else if (state == S_RUN) begin
            a_sr <= a_sr >> 1;
            b_sr <= b_sr >> 1;
            res  <= res_nx;
            br   <= cell_b;
            // Hold on the final bit so the counter never wraps.
            if (!last) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Result registers, loaded only when the last bit completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            diff <= '0;
            bout <= 1'b0;
            ovf  <= 1'b0;
        end else if (state == S_RUN && last) begin
            diff <= res_nx;
            bout <= cell_b;
            ovf  <= (a_msb ^ b_msb) & (a_msb ^ cell_d);
        end
    end

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Self-checking bench for serial_subtractor_ctrl.
// Directed steps plus random operands against an arithmetic model.
module tb_serial_subtractor_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;

    int n_cmp = 0;
    int n_bad = 0;

    serial_subtractor_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Returns {bout, ovf, diff} from plain integer arithmetic.
    function automatic logic [9:0] model(input logic [7:0] ma,
                                         input logic [7:0] mb,
                                         input logic mbin);
        int ua, ub, sa, sb, ib, r, s;
        logic [7:0] d;
        ua = int'(ma);
        ub = int'(mb);
        sa = int'($signed(ma));
        sb = int'($signed(mb));
        ib = int'(mbin);
        r  = ua - ub - ib;
        s  = sa - sb - ib;
        d  = 8'(r);
        return {r < 0, (s < -128) || (s > 127), d};
    endfunction

    // One full operation: start edge, RUN, DONE, back to IDLE.
    task automatic run_op(input logic [7:0] ta,
                          input logic [7:0] tb,
                          input logic tbin,
                          input logic [9:0] exp);
        int  n;
        logic seen;
        a     = ta;
        b     = tb;
        bin   = tbin;
        start = 1'b1;
        tick();
        start = 1'b0;
        a     = 8'($urandom);
        b     = 8'($urandom);
        bin   = 1'($urandom);
        n     = 0;
        seen  = 1'b0;
        while (!seen && n < W + 4) begin
            check("busy_run", 32'(busy), 32'd1);
            tick();
            n++;
            seen = done;
        end
        check("done_latency", n, W);
        check("result", {22'd0, bout, ovf, diff}, {22'd0, exp});
        check("busy_in_done", 32'(busy), 32'd1);
        tick();
        check("idle_flags", {30'd0, busy, done}, 32'd0);
        check("result_hold", {22'd0, bout, ovf, diff}, {22'd0, exp});
    endtask

    initial begin
        int ndone;
        int last_cyc;
        logic [7:0] ra;
        logic [7:0] rb;
        logic rbin;

        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        bin   = 1'b0;
        #1;
        check("reset_outs", {19'd0, busy, done, bout, ovf, diff}, 32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("post_reset_outs", {19'd0, busy, done, bout, ovf, diff}, 32'd0);

        run_op(8'h05, 8'h03, 1'b0, 10'h002);
        run_op(8'h03, 8'h05, 1'b0, 10'h2FE);
        run_op(8'h00, 8'h00, 1'b1, 10'h2FF);
        run_op(8'h80, 8'h01, 1'b0, 10'h17F);
        run_op(8'h7F, 8'hFF, 1'b0, 10'h380);

        // Start during RUN is ignored.
        a     = 8'h10;
        b     = 8'h01;
        bin   = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        a     = 8'hFF;
        b     = 8'hFF;
        start = 1'b1;
        tick();
        start = 1'b0;
        ndone = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done) begin
                ndone++;
                check("ignored_diff", 32'(diff), 32'h0F);
            end
        end
        check("ignored_ndone", ndone, 1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_diff", 32'(diff), 32'h0F);
        end

        // Asynchronous reset mid-operation.
        a     = 8'h55;
        b     = 8'h22;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        #2;
        rst = 1'b1;
        #1;
        check("async_rst", {19'd0, busy, done, bout, ovf, diff}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst   = 1'b0;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done) ndone++;
            if (busy) ndone++;
        end
        check("no_done_after_rst", ndone, 0);
        run_op(8'h09, 8'h04, 1'b0, 10'h005);

        // start held high: one result every W+2 cycles.
        a        = 8'h0A;
        b        = 8'h01;
        bin      = 1'b0;
        start    = 1'b1;
        ndone    = 0;
        last_cyc = -1;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            tick();
            if (done) begin
                ndone++;
                check("stream_res", {22'd0, bout, ovf, diff}, 32'h009);
                if (last_cyc >= 0) check("stream_gap", cyc - last_cyc, W + 2);
                else check("stream_first", cyc, W + 1);
                last_cyc = cyc;
            end
        end
        start = 1'b0;
        check("stream_ndone", ndone, 3);
        for (int i = 0; i < 20 && busy; i++) tick();
        check("stream_drain", 32'(busy), 32'd0);

        // Random operands against the model.
        for (int k = 0; k < 40; k++) begin
            ra   = 8'($urandom);
            rb   = 8'($urandom);
            rbin = 1'($urandom);
            run_op(ra, rb, rbin, model(ra, rb, rbin));
            for (int g = 0; g < int'($urandom_range(2, 0)); g++) tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
